// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and helpers for the memory arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF / NREQ_DEF : default geometry of mem_arbiter
//   PERF_W                             : width of the optional performance counters
//   sat_add()                          : saturating counter increment (0..3 per call)
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;
  localparam int NREQ_DEF   = 4;
  localparam int PERF_W     = 16;

  // Adds a small increment to a counter and sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [PERF_W:0] sum;
    sum = {1'b0, cnt} + {{(PERF_W-1){1'b0}}, inc};
    return sum[PERF_W] ? '1 : sum[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/ram.sv
// ram: simple true dual-port synchronous RAM.
//   we1/addr1/data_in1/data_out1 : port 1 (write enable, address, write data, read data)
//   we2/addr2/data_in2/data_out2 : port 2
// Read data is registered: valid the cycle after the address. A read that
// coincides with a write to the same word on the other port returns the old word.
module ram #(
  parameter int ADDR = 15,
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] data_in1,
  output logic [DATA-1:0] data_out1,
  input  logic            we2,
  input  logic [ADDR-1:0] addr2,
  input  logic [DATA-1:0] data_in2,
  output logic [DATA-1:0] data_out2
);

  // NOTE: the storage array has no reset; clearing it would prevent mapping
  // onto block RAM and its contents must survive a logic reset anyway.
  logic [DATA-1:0] mem [2**ADDR];

  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= data_in1;
    if (we2) mem[addr2] <= data_in2;
    data_out1 <= mem[addr1];
    data_out2 <= mem[addr2];
  end

endmodule

// File: rtl/rr_picker.sv
// rr_picker: circular first-one finder.
//   req   : request vector
//   start : index where the circular scan begins
//   excl  : requests to ignore (one-hot of an already chosen winner)
//   found : at least one non-excluded request is set
//   idx   : first non-excluded request at or after start, wrapping at N
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] cand;

  // Two linear passes replace a modulo index: first the upper segment
  // [start, N-1], then the wrapped segment [0, start-1].
  always_comb begin
    // NOTE: every output gets a default before the scan, otherwise the
    // "nothing found" path would infer latches.
    cand  = req & ~excl;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && cand[j] && (IW'(j) >= start)) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && cand[j] && (IW'(j) < start)) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing a dual-port RAM among NREQ requesters.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_we    : per-requester handshake and direction
//   req_addr/req_wdata            : packed per-requester address and write data
//   rsp_valid/rsp_data            : per-requester read response, one cycle after accept
//   mem_*1 / mem_*2               : RAM port 1 and port 2 drive and read data
// Optional build macro MEM_ARB_PERF_EN adds perf_grants and perf_conflicts
// (saturating 16-bit counters). Without it the ports and counters are absent.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREQ   = NREQ_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*DATA_W-1:0] rsp_data,
  output logic                   mem_we1,
  output logic [ADDR_W-1:0]      mem_addr1,
  output logic [DATA_W-1:0]      mem_data_in1,
  output logic                   mem_we2,
  output logic [ADDR_W-1:0]      mem_addr2,
  output logic [DATA_W-1:0]      mem_data_in2,
  input  logic [DATA_W-1:0]      mem_data_out1,
  input  logic [DATA_W-1:0]      mem_data_out2
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]      perf_grants,
  output logic [PERF_W-1:0]      perf_conflicts
`endif
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]     ptr, ptr_nxt;
  logic [NREQ-1:0]   pend, pend_nxt;
  logic [NREQ-1:0]   pend_port, pend_port_nxt;  // 0 = port 1, 1 = port 2

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  logic              a_found, b_found;
  logic [IW-1:0]     a_idx, b_idx, b_start;
  logic [NREQ-1:0]   a_mask;
  logic              conflict, grant_a, grant_b;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Pick B scans from the slot after A so the pair follows circular order.
  assign b_start = wrap_inc(a_idx);
  assign a_mask  = NREQ'(1) << a_idx;

  rr_picker #(.N(NREQ), .IW(IW)) u_pick_a (
    .req   (req_valid),
    .start (ptr),
    .excl  ('0),
    .found (a_found),
    .idx   (a_idx)
  );

  rr_picker #(.N(NREQ), .IW(IW)) u_pick_b (
    .req   (req_valid),
    .start (b_start),
    .excl  (a_mask),
    .found (b_found),
    .idx   (b_idx)
  );

  always_comb begin
    // A same-address pair involving a write defers B; two reads may share a word.
    conflict = a_found && b_found && (addr_arr[a_idx] == addr_arr[b_idx]) &&
               (req_we[a_idx] || req_we[b_idx]);
    grant_a  = a_found && !rst;
    grant_b  = b_found && !conflict && !rst;

    req_ready     = '0;
    mem_we1       = 1'b0;
    mem_addr1     = '0;
    mem_data_in1  = '0;
    mem_we2       = 1'b0;
    mem_addr2     = '0;
    mem_data_in2  = '0;
    ptr_nxt       = ptr;
    pend_nxt      = '0;
    pend_port_nxt = pend_port;

    if (grant_a) begin
      req_ready[a_idx] = 1'b1;
      mem_we1          = req_we[a_idx];
      mem_addr1        = addr_arr[a_idx];
      mem_data_in1     = wdata_arr[a_idx];
      ptr_nxt          = wrap_inc(a_idx);
      if (!req_we[a_idx]) begin
        pend_nxt[a_idx]      = 1'b1;
        pend_port_nxt[a_idx] = 1'b0;
      end
    end
    if (grant_b) begin
      req_ready[b_idx] = 1'b1;
      mem_we2          = req_we[b_idx];
      mem_addr2        = addr_arr[b_idx];
      mem_data_in2     = wdata_arr[b_idx];
      ptr_nxt          = wrap_inc(b_idx);  // B is the later winner in circular order
      if (!req_we[b_idx]) begin
        pend_nxt[b_idx]      = 1'b1;
        pend_port_nxt[b_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      ptr       <= '0;
      pend      <= '0;
      pend_port <= '0;
    end else begin
      ptr       <= ptr_nxt;
      pend      <= pend_nxt;
      pend_port <= pend_port_nxt;
    end
  end

  assign rsp_valid = pend;

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) rsp_data[i*DATA_W +: DATA_W] = pend_port[i] ? mem_data_out2 : mem_data_out1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants    <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_grants    <= sat_add(perf_grants, {1'b0, grant_a} + {1'b0, grant_b});
      perf_conflicts <= sat_add(perf_conflicts, {1'b0, conflict});
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter driving a ram #(15, 8).
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_data;
  logic            mem_we1, mem_we2;
  logic [AW-1:0]   mem_addr1, mem_addr2;
  logic [DW-1:0]   mem_data_in1, mem_data_in2, mem_data_out1, mem_data_out2;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]     perf_grants, perf_conflicts;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .mem_we1       (mem_we1),
    .mem_addr1     (mem_addr1),
    .mem_data_in1  (mem_data_in1),
    .mem_we2       (mem_we2),
    .mem_addr2     (mem_addr2),
    .mem_data_in2  (mem_data_in2),
    .mem_data_out1 (mem_data_out1),
    .mem_data_out2 (mem_data_out2)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_grants   (perf_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  ram #(15, 8) u_ram (
    .clk       (clk),
    .we1       (mem_we1),
    .addr1     (mem_addr1),
    .data_in1  (mem_data_in1),
    .data_out1 (mem_data_out1),
    .we2       (mem_we2),
    .addr2     (mem_addr2),
    .data_in2  (mem_data_in2),
    .data_out2 (mem_data_out2)
  );

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rsp_of(input int i);
    return rsp_data[i*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), DW'(i));
    settle();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if ({mem_we1, mem_we2} !== 2'b00) begin failures++; $display("FAIL reset_mem_we got=%b exp=00", {mem_we1, mem_we2}); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_grants !== 16'd0) begin failures++; $display("FAIL reset_perf_grants got=%0d exp=0", perf_grants); end
`endif
    idle();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    // Preload two words through requester 0.
    set_req(0, 1'b1, 15'h1234, 8'h56); settle(); step();
    idle(); set_req(0, 1'b1, 15'h3456, 8'h56); settle(); step();
    idle(); set_req(0, 1'b0, 15'h1234, 8'h00); settle();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_of(0) !== 8'h56) begin failures++; $display("FAIL single_rsp_data got=%h exp=56", rsp_of(0)); end
  endtask

  task automatic test_dual_grant();
    // ptr = 1 here: A = 1, B = 2.
    set_req(1, 1'b1, 15'h0010, 8'hA5); set_req(2, 1'b1, 15'h0020, 8'h3C); settle();
    checks++; if (req_ready !== 4'b0110) begin failures++; $display("FAIL dual_wr_ready got=%b exp=0110", req_ready); end
    checks++; if ({mem_we1, mem_we2} !== 2'b11) begin failures++; $display("FAIL dual_wr_we got=%b exp=11", {mem_we1, mem_we2}); end
    step(); idle();
    set_req(1, 1'b0, 15'h0010, 8'h00); set_req(2, 1'b0, 15'h0020, 8'h00); settle();
    checks++; if (req_ready !== 4'b0110) begin failures++; $display("FAIL dual_rd_ready got=%b exp=0110", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b0110) begin failures++; $display("FAIL dual_rsp_valid got=%b exp=0110", rsp_valid); end
    checks++; if (rsp_of(1) !== 8'hA5) begin failures++; $display("FAIL dual_rsp1 got=%h exp=a5", rsp_of(1)); end
    checks++; if (rsp_of(2) !== 8'h3C) begin failures++; $display("FAIL dual_rsp2 got=%h exp=3c", rsp_of(2)); end
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_grants !== 16'd7) begin failures++; $display("FAIL dual_perf_grants got=%0d exp=7", perf_grants); end
`endif
  endtask

  task automatic test_same_addr_reads();
    // ptr = 3: A = 3, B = 2; two reads of one word are both granted.
    set_req(2, 1'b0, 15'h0010, 8'h00); set_req(3, 1'b0, 15'h0010, 8'h00); settle();
    checks++; if (req_ready !== 4'b1100) begin failures++; $display("FAIL same_rd_ready got=%b exp=1100", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b1100) begin failures++; $display("FAIL same_rd_valid got=%b exp=1100", rsp_valid); end
    checks++; if ({rsp_of(2), rsp_of(3)} !== 16'hA5A5) begin failures++; $display("FAIL same_rd_data got=%h exp=a5a5", {rsp_of(2), rsp_of(3)}); end
    // Requester 3 alone moves ptr to 0.
    set_req(3, 1'b0, 15'h0020, 8'h00); settle();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL align_ready got=%b exp=1000", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_of(3) !== 8'h3C) begin failures++; $display("FAIL align_rsp got=%h exp=3c", rsp_of(3)); end
  endtask

  task automatic test_conflict();
    set_req(0, 1'b1, 15'h0100, 8'h11); set_req(1, 1'b0, 15'h0100, 8'h00); settle();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL conflict_ready got=%b exp=0001", req_ready); end
    checks++; if (mem_we2 !== 1'b0) begin failures++; $display("FAIL conflict_we2 got=%b exp=0", mem_we2); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL conflict_no_rsp got=%b exp=0000", rsp_valid); end
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_conflicts !== 16'd1) begin failures++; $display("FAIL conflict_perf got=%0d exp=1", perf_conflicts); end
`endif
    idle(); set_req(1, 1'b0, 15'h0100, 8'h00); settle();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL conflict_retry_ready got=%b exp=0010", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b0010 || rsp_of(1) !== 8'h11) begin failures++; $display("FAIL conflict_retry_rsp got=%b/%h exp=0010/11", rsp_valid, rsp_of(1)); end
  endtask

  task automatic test_read_during_write();
    // ptr = 2: A = 0 (write), B = 1 (read same word) -> deferred.
    set_req(0, 1'b1, 15'h5678, 8'h03); set_req(1, 1'b0, 15'h5678, 8'h00); settle();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rdw_ready got=%b exp=0001", req_ready); end
    step();
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_conflicts !== 16'd2) begin failures++; $display("FAIL rdw_perf got=%0d exp=2", perf_conflicts); end
`endif
    idle(); set_req(1, 1'b0, 15'h5678, 8'h00); settle(); step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b0010 || rsp_of(1) !== 8'h03) begin failures++; $display("FAIL rdw_retry got=%b/%h exp=0010/03", rsp_valid, rsp_of(1)); end
    // ptr = 2: write 1234 and read 3456 together, both granted, old value read.
    set_req(0, 1'b1, 15'h1234, 8'h77); set_req(1, 1'b0, 15'h3456, 8'h00); settle();
    checks++; if (req_ready !== 4'b0011) begin failures++; $display("FAIL rdw_pair_ready got=%b exp=0011", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b0010 || rsp_of(1) !== 8'h56) begin failures++; $display("FAIL rdw_pair_rsp got=%b/%h exp=0010/56", rsp_valid, rsp_of(1)); end
    // ptr = 2: requester 3 reads back the new word, leaving ptr = 0.
    set_req(3, 1'b0, 15'h1234, 8'h00); settle(); step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b1000 || rsp_of(3) !== 8'h77) begin failures++; $display("FAIL rdw_new_word got=%b/%h exp=1000/77", rsp_valid, rsp_of(3)); end
  endtask

  task automatic test_fairness();
    logic [AW-1:0] addr_tab [N];
    logic [DW-1:0] data_tab [N];
    int            rsp_cnt  [N];
    logic [N-1:0]  exp_rdy;
    addr_tab = '{15'h0010, 15'h0020, 15'h0100, 15'h1234};
    data_tab = '{8'hA5, 8'h3C, 8'h11, 8'h77};
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, addr_tab[i], 8'h00);
      settle();
      exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL fair_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      step();
      checks++; if (rsp_valid !== exp_rdy) begin failures++; $display("FAIL fair_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_rdy); end
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          rsp_cnt[i]++;
          checks++; if (rsp_of(i) !== data_tab[i]) begin failures++; $display("FAIL fair_data req=%0d got=%h exp=%h", i, rsp_of(i), data_tab[i]); end
        end
      end
    end
    idle();
    for (int i = 0; i < N; i++) begin
      checks++; if (rsp_cnt[i] != 4) begin failures++; $display("FAIL fair_count req=%0d got=%0d exp=4", i, rsp_cnt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    // ptr = 0: requester 1 alone moves ptr to 2.
    set_req(1, 1'b0, 15'h0020, 8'h00); settle(); step(); idle();
    set_req(3, 1'b0, 15'h0100, 8'h00); settle();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rstmid_pre_ready got=%b exp=1000", req_ready); end
    rst = 1'b1; settle();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rstmid_ready got=%b exp=0000", req_ready); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstmid_rsp_valid got=%b exp=0000", rsp_valid); end
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_grants !== 16'd0 || perf_conflicts !== 16'd0) begin failures++; $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", perf_grants, perf_conflicts); end
`endif
    rst = 1'b0; idle();
    set_req(0, 1'b0, 15'h0010, 8'h00); set_req(1, 1'b0, 15'h0020, 8'h00);
    set_req(2, 1'b0, 15'h0100, 8'h00); set_req(3, 1'b0, 15'h1234, 8'h00); settle();
    checks++; if (req_ready !== 4'b0011) begin failures++; $display("FAIL rstmid_post_ready got=%b exp=0011", req_ready); end
    step(); idle(); settle();
    checks++; if (rsp_valid !== 4'b0011 || rsp_of(0) !== 8'hA5) begin failures++; $display("FAIL rstmid_post_rsp got=%b/%h exp=0011/a5", rsp_valid, rsp_of(0)); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_dual_grant();
    test_same_addr_reads();
    test_conflict();
    test_read_during_write();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
